// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared defaults and FSM state type for the instruction fetch memory
package instr_fetch_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int DEPTH_DEF = 256;
    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = '0;
    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single write port, synchronous read port, read-before-write storage
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 256
)(
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // read samples the pre-edge contents, so a same-index write returns the old word
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: one-cycle instruction fetch memory with program port and clear-on-reset
module instr_fetch_mem
    import instr_fetch_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DEPTH = DEPTH_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF,
    parameter bit                CLEAR_ON_RESET = 1'b1
)(
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Req,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic                     Stall,
    output logic [DATA_W-1:0]        Inst,
    output logic                     InstValid,
    output logic                     Misaligned,
    output logic                     OutOfRange,
    input  logic                     ProgEn,
    input  logic [$clog2(DEPTH)-1:0] ProgAddr,
    input  logic [DATA_W-1:0]        ProgData,
    output logic                     Ready
);
    localparam int IDX_W = $clog2(DEPTH);
    state_t state, state_nx;
    logic [IDX_W-1:0] cnt, cnt_nx;
    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] rdata;
    logic fire, mis, oor, nop_q, we;
    assign Ready = state == RUN;
    assign fire = Ready & Req & ~Stall & ~Reset;
    assign mis = |Addr[1:0];
    assign widx = Addr >> 2;
    assign oor = widx >= ADDR_W'(DEPTH);
    assign we = ~Reset & (state == INIT | (Ready & ProgEn));
    assign Inst = nop_q ? NOP_WORD : rdata;
    imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk(Clk),
        .we(we),
        .waddr(state == INIT ? cnt : ProgAddr),
        .wdata(state == INIT ? NOP_WORD : ProgData),
        .re(fire),
        .raddr(Addr[IDX_W+1:2]),
        .rdata(rdata)
    );
    // state and clear-counter register; reset restarts clearing from index 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= CLEAR_ON_RESET ? INIT : RUN;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end
    // clear one word per cycle in INIT, leave after the last index
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (state == INIT) begin
            cnt_nx = cnt + 1'b1;
            state_nx = cnt == IDX_W'(DEPTH - 1) ? RUN : INIT;
        end
    end
    // response qualifiers; frozen while stalled, invalid fetches force NOP_WORD
    always_ff @(posedge Clk) begin
        if (Reset) begin
            InstValid <= 1'b0;
            Misaligned <= 1'b0;
            OutOfRange <= 1'b0;
            nop_q <= 1'b1;
        end else if (!Stall) begin
            InstValid <= fire;
            if (fire) begin
                Misaligned <= mis;
                OutOfRange <= oor;
                nop_q <= mis | oor;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed and model-checked bench for instr_fetch_mem
module tb_instr_fetch_mem;
    logic Clk = 0, Reset = 0, Req = 0, Stall = 0, ProgEn = 0;
    logic [31:0] Addr = 0, ProgData = 0, Inst;
    logic [7:0] ProgAddr = 0;
    logic InstValid, Misaligned, OutOfRange, Ready;
    logic Reset_b = 0, Req_b = 0, Stall_b = 0, ProgEn_b = 0;
    logic [31:0] Addr_b = 0, ProgData_b = 0, Inst_b;
    logic [3:0] ProgAddr_b = 0;
    logic InstValid_b, Misaligned_b, OutOfRange_b, Ready_b;
    int vectors = 0, miscompares = 0;

    always #5 Clk = ~Clk;

    instr_fetch_mem dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .Stall(Stall),
        .Inst(Inst), .InstValid(InstValid), .Misaligned(Misaligned), .OutOfRange(OutOfRange),
        .ProgEn(ProgEn), .ProgAddr(ProgAddr), .ProgData(ProgData), .Ready(Ready)
    );

    instr_fetch_mem #(.DEPTH(16), .NOP_WORD(32'hDEADBEEF), .CLEAR_ON_RESET(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset_b), .Req(Req_b), .Addr(Addr_b), .Stall(Stall_b),
        .Inst(Inst_b), .InstValid(InstValid_b), .Misaligned(Misaligned_b), .OutOfRange(OutOfRange_b),
        .ProgEn(ProgEn_b), .ProgAddr(ProgAddr_b), .ProgData(ProgData_b), .Ready(Ready_b)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        Req = 1; Addr = a;
        tick();
        Req = 0;
    endtask

    task automatic test_reset();
        int n;
        bit bad;
        Reset = 1; Req = 1; ProgEn = 1;
        tick();
        Reset = 0;
        vectors++;
        if (Inst !== 32'h0 || InstValid !== 1'b0 || Misaligned !== 1'b0 || OutOfRange !== 1'b0 || Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: Inst=%h V=%b M=%b O=%b R=%b, want 0 0 0 0 0", Inst, InstValid, Misaligned, OutOfRange, Ready);
        end
        Addr = 0; ProgAddr = 7; ProgData = 32'hCAFEF00D;
        n = 0; bad = 0;
        while (!Ready && n < 1000) begin
            if (InstValid !== 1'b0) bad = 1;
            n++;
            tick();
        end
        Req = 0; ProgEn = 0;
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL init_length: Ready low for %0d cycles, want 256", n);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL init_valid: InstValid=1 during INIT, want 0");
        end
        fetch(32'h3FC);
        vectors++;
        if (Inst !== 32'h0 || InstValid !== 1'b1 || Misaligned !== 1'b0 || OutOfRange !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_last: Inst=%h V=%b M=%b O=%b, want 00000000 1 0 0", Inst, InstValid, Misaligned, OutOfRange);
        end
        fetch(32'h1C);
        vectors++;
        if (Inst !== 32'h0 || InstValid !== 1'b1) begin
            miscompares++;
            $display("FAIL init_prog_ignored: Inst=%h V=%b, want 00000000 1", Inst, InstValid);
        end
    endtask

    task automatic test_prog_fetch();
        ProgEn = 1; ProgAddr = 3; ProgData = 32'h2002000A;
        tick();
        ProgEn = 0;
        fetch(32'h0C);
        vectors++;
        if (Inst !== 32'h2002000A || InstValid !== 1'b1 || Misaligned !== 1'b0 || OutOfRange !== 1'b0) begin
            miscompares++;
            $display("FAIL prog_fetch: Inst=%h V=%b M=%b O=%b, want 2002000a 1 0 0", Inst, InstValid, Misaligned, OutOfRange);
        end
        tick();
        vectors++;
        if (Inst !== 32'h2002000A || InstValid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: Inst=%h V=%b, want 2002000a 0", Inst, InstValid);
        end
    endtask

    task automatic test_flags();
        fetch(32'h0E);
        vectors++;
        if (Inst !== 32'h0 || InstValid !== 1'b1 || Misaligned !== 1'b1 || OutOfRange !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned: Inst=%h V=%b M=%b O=%b, want 00000000 1 1 0", Inst, InstValid, Misaligned, OutOfRange);
        end
        fetch(32'h400);
        vectors++;
        if (Inst !== 32'h0 || InstValid !== 1'b1 || Misaligned !== 1'b0 || OutOfRange !== 1'b1) begin
            miscompares++;
            $display("FAIL out_of_range: Inst=%h V=%b M=%b O=%b, want 00000000 1 0 1", Inst, InstValid, Misaligned, OutOfRange);
        end
        fetch(32'h401);
        vectors++;
        if (Inst !== 32'h0 || Misaligned !== 1'b1 || OutOfRange !== 1'b1) begin
            miscompares++;
            $display("FAIL both_flags: Inst=%h M=%b O=%b, want 00000000 1 1", Inst, Misaligned, OutOfRange);
        end
        fetch(32'h8000000C);
        vectors++;
        if (Inst !== 32'h0 || Misaligned !== 1'b0 || OutOfRange !== 1'b1) begin
            miscompares++;
            $display("FAIL no_wrap: Inst=%h M=%b O=%b, want 00000000 0 1", Inst, Misaligned, OutOfRange);
        end
    endtask

    task automatic test_rbw();
        ProgEn = 1; ProgAddr = 5; ProgData = 32'h11111111;
        tick();
        ProgData = 32'h22222222; Req = 1; Addr = 32'h14;
        tick();
        ProgEn = 0; Req = 0;
        vectors++;
        if (Inst !== 32'h11111111 || InstValid !== 1'b1) begin
            miscompares++;
            $display("FAIL rbw_old: Inst=%h V=%b, want 11111111 1", Inst, InstValid);
        end
        fetch(32'h14);
        vectors++;
        if (Inst !== 32'h22222222) begin
            miscompares++;
            $display("FAIL rbw_new: Inst=%h, want 22222222", Inst);
        end
    endtask

    task automatic test_stall();
        fetch(32'h0C);
        Stall = 1; Req = 1; Addr = 32'h14;
        ProgEn = 1; ProgAddr = 9; ProgData = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            ProgEn = 0;
            vectors++;
            if (Inst !== 32'h2002000A || InstValid !== 1'b1 || Misaligned !== 1'b0 || OutOfRange !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: Inst=%h V=%b M=%b O=%b, want 2002000a 1 0 0", i, Inst, InstValid, Misaligned, OutOfRange);
            end
        end
        Stall = 0; Req = 0;
        tick();
        vectors++;
        if (Inst !== 32'h2002000A || InstValid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drop: Inst=%h V=%b, want 2002000a 0", Inst, InstValid);
        end
        fetch(32'h24);
        vectors++;
        if (Inst !== 32'hA5A5A5A5 || InstValid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_write: Inst=%h V=%b, want a5a5a5a5 1", Inst, InstValid);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        Reset = 1;
        tick();
        Reset = 0;
        repeat (100) tick();
        Reset = 1;
        tick();
        Reset = 0;
        n = 0;
        while (!Ready && n < 1000) begin
            n++;
            tick();
        end
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL restart_init: Ready low for %0d cycles, want 256", n);
        end
        fetch(32'h0C);
        vectors++;
        if (Inst !== 32'h0 || InstValid !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clear: Inst=%h V=%b, want 00000000 1", Inst, InstValid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] model [256];
        logic [31:0] ei = 0, a;
        logic ev = 0, em = 0, eo = 0, rq, st, pe;
        logic [7:0] pa;
        logic [31:0] pd;
        int sel, errs = 0;
        for (int i = 0; i < 256; i++) model[i] = 0;
        for (int i = 0; i < 5000; i++) begin
            rq = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 3) == 0;
            pe = 1'($urandom_range(0, 1));
            pa = 8'($urandom);
            pd = $urandom;
            sel = $urandom_range(0, 7);
            a = sel == 0 ? $urandom : sel == 1 ? ($urandom & 32'h7FF) : {22'h0, 8'($urandom), 2'b00};
            Req = rq; Stall = st; ProgEn = pe; ProgAddr = pa; ProgData = pd; Addr = a;
            tick();
            if (!st) begin
                ev = rq;
                if (rq) begin
                    em = a[1:0] != 0;
                    eo = a >= 32'h400;
                    ei = (em || eo) ? 32'h0 : model[a[9:2]];
                end
            end
            if (pe) model[pa] = pd;
            vectors++;
            if (Inst !== ei || InstValid !== ev || Misaligned !== em || OutOfRange !== eo) begin
                miscompares++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: Inst=%h V=%b M=%b O=%b, want %h %b %b %b", i, Inst, InstValid, Misaligned, OutOfRange, ei, ev, em, eo);
            end
        end
        Req = 0; Stall = 0; ProgEn = 0;
    endtask

    task automatic test_no_clear();
        Reset_b = 1;
        @(posedge Clk); #1;
        Reset_b = 0;
        vectors++;
        if (Ready_b !== 1'b1 || Inst_b !== 32'hDEADBEEF || InstValid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL noclear_reset: R=%b Inst=%h V=%b, want 1 deadbeef 0", Ready_b, Inst_b, InstValid_b);
        end
        ProgEn_b = 1; ProgAddr_b = 2; ProgData_b = 32'h12345678;
        tick();
        ProgData_b = 32'h0; Reset_b = 1; Req_b = 1; Addr_b = 32'h08;
        tick();
        Reset_b = 0; ProgEn_b = 0; Req_b = 0;
        vectors++;
        if (InstValid_b !== 1'b0 || Inst_b !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL reset_priority: V=%b Inst=%h, want 0 deadbeef", InstValid_b, Inst_b);
        end
        Req_b = 1; Addr_b = 32'h08;
        tick();
        Req_b = 0;
        vectors++;
        if (Inst_b !== 32'h12345678 || InstValid_b !== 1'b1) begin
            miscompares++;
            $display("FAIL noclear_retain: Inst=%h V=%b, want 12345678 1", Inst_b, InstValid_b);
        end
        Req_b = 1; Addr_b = 32'h40;
        tick();
        Req_b = 0;
        vectors++;
        if (Inst_b !== 32'hDEADBEEF || OutOfRange_b !== 1'b1 || Misaligned_b !== 1'b0) begin
            miscompares++;
            $display("FAIL small_oor: Inst=%h O=%b M=%b, want deadbeef 1 0", Inst_b, OutOfRange_b, Misaligned_b);
        end
    endtask

    initial begin
        test_reset();
        test_prog_fetch();
        test_flags();
        test_rbw();
        test_stall();
        test_reset_mid_init();
        test_random();
        test_no_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
